// File: rtl/phase_sched_pkg.sv
// Shared types and default timing constants for the signalised-intersection
// green-time scheduler.
package phase_sched_pkg;

  typedef enum logic [1:0] {
    ALL_RED       = 2'd0,
    GREEN         = 2'd1,
    YELLOW        = 2'd2,
    PREEMPT_GREEN = 2'd3
  } phase_state_e;

  localparam int DEF_N_APPR    = 4;
  localparam int DEF_MIN_GREEN = 5;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_TIMER_W   = 8;

endpackage

// File: rtl/phase_scheduler_rr_pick.sv
// Round-robin requester search: rotate the demand vector so the slot after
// 'last' sits at bit 0, then priority-encode the lowest set bit.
module rr_pick #(
  parameter int N_APPR = 4,
  parameter int IW     = $clog2(N_APPR)
) (
  input  logic [N_APPR-1:0] req,
  input  logic [IW-1:0]     last,
  output logic              valid,
  output logic [IW-1:0]     next
);

  logic [2*N_APPR-1:0] dbl_s;
  logic [N_APPR-1:0]   rot_s;
  logic [IW:0]         start_s;
  logic [IW:0]         off_s;
  logic [IW:0]         sum_s;

  // search start is last+1 wrapped modulo N_APPR
  always_comb begin
    if (int'(last) >= N_APPR - 1) begin
      start_s = '0;
    end else begin
      start_s = {1'b0, last} + (IW+1)'(1);
    end
  end

  // rotate and priority-encode; descending loop lets the lowest offset win
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[start_s +: N_APPR];
    valid = 1'b0;
    off_s = '0;
    for (int k = N_APPR - 1; k >= 0; k--) begin
      valid = valid | rot_s[k];
      off_s = rot_s[k] ? (IW+1)'(k) : off_s;
    end
    sum_s = start_s + off_s;
    if (sum_s >= (IW+1)'(N_APPR)) begin
      next = IW'(sum_s - (IW+1)'(N_APPR));
    end else begin
      next = IW'(sum_s);
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Green-time arbiter: round-robin service with min/max green, fixed yellow,
// all-red clearance and emergency preemption; all lamp outputs registered.
module phase_scheduler
  import phase_sched_pkg::*;
#(
  parameter int N_APPR    = DEF_N_APPR,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int TIMER_W   = DEF_TIMER_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_APPR-1:0]         req,
  input  logic                      emerg_req,
  input  logic [$clog2(N_APPR)-1:0] emerg_id,
  output logic [N_APPR-1:0]         green,
  output logic [N_APPR-1:0]         yellow,
  output logic [N_APPR-1:0]         red,
  output logic [$clog2(N_APPR)-1:0] active_id,
  output logic                      preempt_active,
  output logic                      phase_done
);

  localparam int IW = $clog2(N_APPR);
  localparam logic [TIMER_W-1:0] ALLRED_LIM = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] MIN_LIM    = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LIM    = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LIM    = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT  = {TIMER_W{1'b1}};

  function automatic logic [N_APPR-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_APPR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  phase_state_e        state_r;
  phase_state_e        state_nx_s;
  logic [TIMER_W-1:0]  timer_r;
  logic [IW-1:0]       idx_nx_s;
  logic                pick_valid_s;
  logic [IW-1:0]       pick_idx_s;
  logic                others_s;
  logic [N_APPR-1:0]   green_nx_s;
  logic [N_APPR-1:0]   yellow_nx_s;

  rr_pick #(.N_APPR(N_APPR), .IW(IW)) u_pick (
    .req   (req),
    .last  (active_id),
    .valid (pick_valid_s),
    .next  (pick_idx_s)
  );

  assign others_s = |(req & ~onehot(active_id));

  // next-state decision; active_id doubles as the served-approach register
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = active_id;
    case (state_r)
      ALL_RED: begin
        if (timer_r >= ALLRED_LIM) begin
          if (emerg_req) begin
            state_nx_s = PREEMPT_GREEN;
            idx_nx_s   = emerg_id;
          end else if (pick_valid_s) begin
            state_nx_s = GREEN;
            idx_nx_s   = pick_idx_s;
          end else begin
            state_nx_s = ALL_RED;
          end
        end else begin
          state_nx_s = ALL_RED;
        end
      end
      GREEN: begin
        if (emerg_req) begin
          state_nx_s = (emerg_id == active_id) ? PREEMPT_GREEN : YELLOW;
        end else if (others_s && ((timer_r >= MIN_LIM && !req[active_id]) ||
                                  timer_r >= MAX_LIM)) begin
          state_nx_s = YELLOW;
        end else begin
          state_nx_s = GREEN;
        end
      end
      YELLOW: begin
        if (timer_r >= YEL_LIM) begin
          state_nx_s = ALL_RED;
        end else begin
          state_nx_s = YELLOW;
        end
      end
      PREEMPT_GREEN: begin
        if (!emerg_req || emerg_id != active_id) begin
          state_nx_s = YELLOW;
        end else begin
          state_nx_s = PREEMPT_GREEN;
        end
      end
      default: begin
        state_nx_s = ALL_RED;
      end
    endcase
  end

  // lamp plan for the upcoming cycle
  always_comb begin
    green_nx_s  = '0;
    yellow_nx_s = '0;
    case (state_nx_s)
      GREEN, PREEMPT_GREEN: green_nx_s  = onehot(idx_nx_s);
      YELLOW:               yellow_nx_s = onehot(idx_nx_s);
      default: begin
        green_nx_s  = '0;
        yellow_nx_s = '0;
      end
    endcase
  end

  // state, phase timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ALL_RED;
      timer_r        <= '0;
      green          <= '0;
      yellow         <= '0;
      red            <= '1;
      active_id      <= IW'(N_APPR - 1);
      preempt_active <= 1'b0;
      phase_done     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        timer_r <= '0;
      end else if (timer_r != TIMER_SAT) begin
        timer_r <= timer_r + TIMER_W'(1);
      end else begin
        timer_r <= timer_r;
      end
      green          <= green_nx_s;
      yellow         <= yellow_nx_s;
      red            <= ~(green_nx_s | yellow_nx_s);
      active_id      <= idx_nx_s;
      preempt_active <= (state_nx_s == PREEMPT_GREEN);
      phase_done     <= (state_r == YELLOW) && (state_nx_s == ALL_RED);
    end
  end

endmodule
